// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: requester ids,
// the read-return tag and the grant function.
package ram_arb_pkg;

    localparam logic ARB_ID_A = 1'b0;
    localparam logic ARB_ID_B = 1'b1;

    // Tag that follows a read through the RAM so its data can be steered back.
    typedef struct packed {
        logic valid;
        logic id;
    } arb_tag_t;

    // Grant vector {b, a}. A lone requester always wins; on contention the
    // lock owner wins if a lock is held, otherwise the priority holder.
    function automatic logic [1:0] arb_grant(
        input logic a_req,
        input logic b_req,
        input logic pri,
        input logic lock,
        input logic owner
    );
        logic [1:0] grant;
        logic       b_wins;
        b_wins = lock ? (owner == ARB_ID_B) : (pri == ARB_ID_B);
        case ({a_req, b_req})
            2'b10:   grant = 2'b01;
            2'b01:   grant = 2'b10;
            2'b11:   grant = b_wins ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/ram_arb.sv
// Round-robin arbiter with optional burst lock sharing one single-port
// registered-read RAM between requesters A and B. The winning command is
// registered onto the RAM port and read data is steered back by a 2-stage tag.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int  SIZE    = 256,
    parameter int  DATA_WD = 8,
    localparam int SIZE_WD = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req_i,
    input  logic               a_wr_i,
    input  logic               a_lck_i,
    input  logic [SIZE_WD-1:0] a_adr_i,
    input  logic [DATA_WD-1:0] a_dat_i,
    output logic               a_ack_o,
    output logic               a_rd_val_o,
    output logic [DATA_WD-1:0] a_rd_dat_o,
    input  logic               b_req_i,
    input  logic               b_wr_i,
    input  logic               b_lck_i,
    input  logic [SIZE_WD-1:0] b_adr_i,
    input  logic [DATA_WD-1:0] b_dat_i,
    output logic               b_ack_o,
    output logic               b_rd_val_o,
    output logic [DATA_WD-1:0] b_rd_dat_o,
    output logic [SIZE_WD-1:0] ram_adr_o,
    output logic               ram_wr_val_o,
    output logic [DATA_WD-1:0] ram_wr_dat_o,
    output logic               ram_rd_val_o,
    input  logic               ram_rd_val_i,
    input  logic [DATA_WD-1:0] ram_rd_dat_i
);

    logic               pri_r;
    logic               lock_r;
    logic               owner_r;
    arb_tag_t           tag1_r;
    arb_tag_t           tag2_r;

    logic [1:0]         grant_s;
    logic               accept_s;
    logic               win_id_s;
    logic               win_wr_s;
    logic               win_lck_s;
    logic [SIZE_WD-1:0] win_adr_s;
    logic [DATA_WD-1:0] win_dat_s;

    // Grant and winner-command mux; nothing is acknowledged while in reset.
    always_comb begin
        grant_s   = 2'b00;
        win_id_s  = ARB_ID_A;
        win_wr_s  = a_wr_i;
        win_lck_s = a_lck_i;
        win_adr_s = a_adr_i;
        win_dat_s = a_dat_i;
        if (rst) begin
            grant_s = 2'b00;
        end else begin
            grant_s = arb_grant(a_req_i, b_req_i, pri_r, lock_r, owner_r);
        end
        if (grant_s[1]) begin
            win_id_s  = ARB_ID_B;
            win_wr_s  = b_wr_i;
            win_lck_s = b_lck_i;
            win_adr_s = b_adr_i;
            win_dat_s = b_dat_i;
        end else begin
            win_id_s  = ARB_ID_A;
        end
    end

    assign accept_s = grant_s[0] | grant_s[1];
    assign a_ack_o  = grant_s[0];
    assign b_ack_o  = grant_s[1];

    // Priority/lock update on acceptance. A command from the non-owner that
    // slips through while the other side holds a lock (owner idle) leaves the
    // lock and priority untouched: only the owner can release its lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_r   <= ARB_ID_A;
            lock_r  <= 1'b0;
            owner_r <= ARB_ID_A;
        end else if (accept_s && !(lock_r && (win_id_s != owner_r))) begin
            if (win_lck_s) begin
                lock_r  <= 1'b1;
                owner_r <= win_id_s;
            end else begin
                lock_r  <= 1'b0;
                pri_r   <= ~win_id_s;
            end
        end
    end

    // RAM command register: strobes pulse per accepted command, adr/dat hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_adr_o    <= '0;
            ram_wr_dat_o <= '0;
            ram_wr_val_o <= 1'b0;
            ram_rd_val_o <= 1'b0;
        end else begin
            ram_wr_val_o <= accept_s & win_wr_s;
            ram_rd_val_o <= accept_s & ~win_wr_s;
            if (accept_s) begin
                ram_adr_o    <= win_adr_s;
                ram_wr_dat_o <= win_dat_s;
            end
        end
    end

    // Read tag pipeline aligned with the RAM's one-cycle registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_r <= '{valid: 1'b0, id: ARB_ID_A};
            tag2_r <= '{valid: 1'b0, id: ARB_ID_A};
        end else begin
            tag1_r <= '{valid: accept_s & ~win_wr_s, id: win_id_s};
            tag2_r <= tag1_r;
        end
    end

    // Return steering; reads in flight across a reset never signal valid.
    assign a_rd_val_o = ~rst & ram_rd_val_i & tag2_r.valid & (tag2_r.id == ARB_ID_A);
    assign b_rd_val_o = ~rst & ram_rd_val_i & tag2_r.valid & (tag2_r.id == ARB_ID_B);
    assign a_rd_dat_o = ram_rd_dat_i;
    assign b_rd_dat_o = ram_rd_dat_i;

endmodule

// File: tb/tb_ram_arb.sv
// Self-checking bench for ram_arb: a behavioural RAM plus a transaction-level
// reference model (acceptance-order memory image, queue of expected returns).
module tb_ram_arb;

    localparam int SIZE = 256;
    localparam int DW   = 8;
    localparam int AW   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_req, a_wr, a_lck, a_ack, a_rd_val;
    logic [AW-1:0] a_adr;
    logic [DW-1:0] a_dat, a_rd_dat;
    logic          b_req, b_wr, b_lck, b_ack, b_rd_val;
    logic [AW-1:0] b_adr;
    logic [DW-1:0] b_dat, b_rd_dat;
    logic [AW-1:0] ram_adr;
    logic          ram_wr_val, ram_rd_val;
    logic [DW-1:0] ram_wr_dat;
    logic          ram_rv = 1'b0;
    logic [DW-1:0] ram_rd = 8'h00;
    logic [DW-1:0] mem [SIZE];

    // Behavioural single-port RAM with a one-cycle registered read (not reset).
    always @(posedge clk) begin
        if (ram_wr_val) mem[ram_adr] <= ram_wr_dat;
        ram_rv <= ram_rd_val;
        if (ram_rd_val) ram_rd <= mem[ram_adr];
    end

    ram_arb #(.SIZE(SIZE), .DATA_WD(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req_i(a_req), .a_wr_i(a_wr), .a_lck_i(a_lck), .a_adr_i(a_adr), .a_dat_i(a_dat),
        .a_ack_o(a_ack), .a_rd_val_o(a_rd_val), .a_rd_dat_o(a_rd_dat),
        .b_req_i(b_req), .b_wr_i(b_wr), .b_lck_i(b_lck), .b_adr_i(b_adr), .b_dat_i(b_dat),
        .b_ack_o(b_ack), .b_rd_val_o(b_rd_val), .b_rd_dat_o(b_rd_dat),
        .ram_adr_o(ram_adr), .ram_wr_val_o(ram_wr_val), .ram_wr_dat_o(ram_wr_dat),
        .ram_rd_val_o(ram_rd_val), .ram_rd_val_i(ram_rv), .ram_rd_dat_i(ram_rd)
    );

    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] dat;
    } rd_t;

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    bit            m_pri, m_lock, m_owner;
    bit            e_wv, e_rv;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [DW-1:0] ref_mem [SIZE];
    rd_t           pend[$];
    bit            exp_a, exp_b;
    bit            a_hold, b_hold;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: called just after a negedge with inputs applied.
    task automatic step();
        bit            win_b, ev_a, ev_b, id, wr, lck;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat, edat;
        rd_t           r;
        #1;
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (!rst) begin
            if (a_req && !b_req) exp_a = 1'b1;
            else if (b_req && !a_req) exp_b = 1'b1;
            else if (a_req && b_req) begin
                win_b = m_lock ? m_owner : m_pri;
                if (win_b) exp_b = 1'b1; else exp_a = 1'b1;
            end
        end
        check_val("a_ack", a_ack, exp_a);
        check_val("b_ack", b_ack, exp_b);

        if (rst) pend.delete();
        ev_a = 1'b0; ev_b = 1'b0; edat = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            if (r.id) ev_b = 1'b1; else ev_a = 1'b1;
            edat = r.dat;
        end
        check_val("a_rd_val", a_rd_val, ev_a);
        check_val("b_rd_val", b_rd_val, ev_b);
        if (ev_a || ev_b) begin
            check_val("a_rd_dat", a_rd_dat, edat);
            check_val("b_rd_dat", b_rd_dat, edat);
        end
        check_val("rd_dat_follow", a_rd_dat, ram_rd);
        check_val("ram_wr_val", ram_wr_val, e_wv);
        check_val("ram_rd_val", ram_rd_val, e_rv);
        check_val("ram_adr", ram_adr, e_adr);
        check_val("ram_wr_dat", ram_wr_dat, e_dat);

        // model state after the coming edge
        if (rst) begin
            m_pri = 1'b0; m_lock = 1'b0; m_owner = 1'b0;
            e_adr = '0; e_dat = '0; e_wv = 1'b0; e_rv = 1'b0;
        end else if (exp_a || exp_b) begin
            id  = exp_b;
            wr  = id ? b_wr  : a_wr;
            lck = id ? b_lck : a_lck;
            adr = id ? b_adr : a_adr;
            dat = id ? b_dat : a_dat;
            e_adr = adr; e_dat = dat; e_wv = wr; e_rv = !wr;
            if (wr) ref_mem[adr] = dat;
            else pend.push_back('{due: cyc + 2, id: id, dat: ref_mem[adr]});
            if (m_lock && id != m_owner) begin
                m_lock = m_lock;
            end else if (lck) begin
                m_lock = 1'b1; m_owner = id;
            end else begin
                m_lock = 1'b0; m_pri = !id;
            end
        end else begin
            e_wv = 1'b0; e_rv = 1'b0;
        end
        a_hold = a_req && !exp_a;
        b_hold = b_req && !exp_b;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_drive();
        if (!a_hold) begin
            a_req = ($urandom_range(0, 3) != 0);
            a_wr  = 1'($urandom_range(0, 1));
            a_lck = ($urandom_range(0, 5) == 0);
            a_adr = ($urandom_range(0, 9) == 0) ? 8'hFF : AW'($urandom_range(0, 15));
            a_dat = DW'($urandom_range(0, 255));
        end
        if (!b_hold) begin
            b_req = ($urandom_range(0, 3) != 0);
            b_wr  = 1'($urandom_range(0, 1));
            b_lck = ($urandom_range(0, 5) == 0);
            b_adr = ($urandom_range(0, 9) == 0) ? 8'hFF : AW'($urandom_range(0, 15));
            b_dat = DW'($urandom_range(0, 255));
        end
        rst = ($urandom_range(0, 99) == 0);
    endtask

    task automatic idle(input int n);
        a_req = 1'b0; b_req = 1'b0; a_lck = 1'b0; b_lck = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        a_req = 1'b0; b_req = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_wr = 1'b0; a_lck = 1'b0; a_adr = '0; a_dat = '0;
        b_req = 1'b0; b_wr = 1'b0; b_lck = 1'b0; b_adr = '0; b_dat = '0;
        m_pri = 1'b0; m_lock = 1'b0; m_owner = 1'b0;
        e_wv = 1'b0; e_rv = 1'b0; e_adr = '0; e_dat = '0;
        a_hold = 1'b0; b_hold = 1'b0;
        @(negedge clk);

        // reset then idle
        repeat (3) step();
        rst = 1'b0;
        idle(2);

        // fill the RAM so every read has defined data
        for (int i = 0; i < SIZE; i++) begin
            a_req = 1'b1; a_wr = 1'b1; a_lck = 1'b0; a_adr = AW'(i); a_dat = DW'(i * 7 + 3);
            step();
        end
        idle(2);

        // single requester: write 5 = 0x3C, then read it back
        a_req = 1'b1; a_wr = 1'b1; a_adr = 8'd5; a_dat = 8'h3C; step();
        a_wr = 1'b0; step();
        a_req = 1'b0; step();
        #1;
        check_val("single_a_rd_val", a_rd_val, 1'b1);
        check_val("single_a_rd_dat", a_rd_dat, 8'h3C);
        check_val("single_b_rd_val", b_rd_val, 1'b0);
        idle(2);

        // contention: preload 1/2, reset priority, then both read continuously
        a_req = 1'b1; a_wr = 1'b1; a_adr = 8'd1; a_dat = 8'h11; step();
        a_adr = 8'd2; a_dat = 8'h22; step();
        idle(2);
        do_reset();
        a_req = 1'b1; a_wr = 1'b0; a_lck = 1'b0; a_adr = 8'd1;
        b_req = 1'b1; b_wr = 1'b0; b_lck = 1'b0; b_adr = 8'd2;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val("contend_a_ack", a_ack, (i % 2 == 0));
            if (i >= 2) check_val("contend_rd_dat", a_rd_dat, (i % 2 == 0) ? 8'h11 : 8'h22);
            step();
        end
        idle(3);

        // lock: A bursts 4 writes (lck 1,1,1,0) against a continuous B
        do_reset();
        b_req = 1'b1; b_wr = 1'b0; b_lck = 1'b0; b_adr = 8'd3;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                a_req = 1'b1; a_wr = 1'b1; a_lck = (i < 3); a_adr = AW'(16 + i); a_dat = DW'(8'h50 + i);
            end else if (i == 4) begin
                a_req = 1'b0;
            end else begin
                a_req = 1'b1; a_wr = 1'b1; a_lck = 1'b0; a_adr = 8'd20; a_dat = 8'h99;
            end
            #1;
            check_val("lock_a_ack", a_ack, (i != 4));
            check_val("lock_b_ack", b_ack, (i == 4));
            step();
        end
        idle(3);

        // write-then-read hazard across requesters, top address too
        a_req = 1'b1; a_wr = 1'b1; a_adr = 8'd7; a_dat = 8'hA5; step();
        a_req = 1'b0; b_req = 1'b1; b_wr = 1'b0; b_adr = 8'd7; step();
        b_req = 1'b0; step();
        #1;
        check_val("hazard_b_rd_val", b_rd_val, 1'b1);
        check_val("hazard_b_rd_dat", b_rd_dat, 8'hA5);
        check_val("hazard_a_rd_val", a_rd_val, 1'b0);
        a_req = 1'b1; a_wr = 1'b1; a_adr = 8'hFF; a_dat = 8'h5A; step();
        a_req = 1'b0; b_req = 1'b1; b_wr = 1'b0; b_adr = 8'hFF; step();
        idle(3);

        // reset mid-operation drops the in-flight read
        b_req = 1'b1; b_wr = 1'b0; b_adr = 8'd7; step();
        b_req = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        #1; check_val("rstmid_b_rd_val_t2", b_rd_val, 1'b0);
        step();
        #1; check_val("rstmid_b_rd_val_t3", b_rd_val, 1'b0);
        step();

        // a lock held by B is released by reset
        b_req = 1'b1; b_wr = 1'b1; b_lck = 1'b1; b_adr = 8'd9; b_dat = 8'h77; step();
        b_req = 1'b0; b_lck = 1'b0; step();
        do_reset();
        a_req = 1'b1; a_wr = 1'b0; a_adr = 8'd1;
        b_req = 1'b1; b_wr = 1'b0; b_adr = 8'd2;
        #1; check_val("rst_unlock_a_ack", a_ack, 1'b1);
        step();
        idle(3);

        // randomized traffic
        a_hold = 1'b0; b_hold = 1'b0;
        repeat (3000) begin
            rand_drive();
            step();
        end
        rst = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
